sccb_target: RTL and testbench
==============================

# sccb_target

SCCB/I2C target (slave) that answers the camera-configuration master over the two-wire bus. It emulates the OV7670 register port at device address 7'h21 using a 256 x 8 internal register file. Its uses are closed-loop simulation and FPGA loopback of the `sccb_master` configuration path without a physical camera. Every accepted register write is also mirrored on a one-cycle strobe port.

## Interface

Parameters:
- `DEV_ADDR`, default 7'h21: 7-bit bus address the block responds to.

Ports:
- `i_clk`, in, 1: system clock. Must run at least 16x the SCL frequency.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_scl`, in, 1: bus clock. Open-drain; read only.
- `io_sda`, inout, 1: bus data. Open-drain: the block drives only 1'b0 or 1'bZ.
- `o_busy`, out, 1: high from a START addressed to `DEV_ADDR` until the next STOP.
- `o_wr_valid`, out, 1: one-cycle strobe when a data byte is written to the register file.
- `o_wr_addr`, out, 8: register address of that write. Valid while `o_wr_valid` is high.
- `o_wr_data`, out, 8: data of that write. Valid while `o_wr_valid` is high.
- `o_sub_addr`, out, 8: current register pointer.

## Operation

- SCL and SDA each pass through a 2-FF synchronizer, then an edge register. All decisions use these synchronized copies.
- Bus conditions:
  - START: SDA falls while SCL is high. Accepted in any state, so it also serves as a repeated START.
  - STOP: SDA rises while SCL is high. Returns the FSM to IDLE from any state.
- Bit transfer:
  - Bits are sampled on SCL rising edges, MSB first.
  - SDA is changed only on SCL falling edges.
  - Each byte is 8 bits followed by a 9th (ACK) bit.
- FSM states: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - IDLE -> DEV on START.
  - DEV: after 8 bits, if `byte[7:1] == DEV_ADDR` go to DEV_ACK; otherwise go to IGNORE. IGNORE releases SDA until the next START or STOP.
  - DEV_ACK: if the R/W bit = 0, go to SUB. If R/W = 1, go to RDATA and load the shift register with `reg[sub_addr]`.
  - SUB: the byte becomes `sub_addr`. Then SUB_ACK -> WDATA.
  - WDATA: write the byte to `reg[sub_addr]`, pulse `o_wr_valid`, increment `sub_addr`. Then WDATA_ACK -> WDATA, so further bytes land at consecutive addresses.
  - RDATA: drive SDA low for 0 bits and release it for 1 bits. After the 8th bit go to RDATA_ACK and release SDA.
  - RDATA_ACK: sample the 9th bit.
    - Low (master ACK): increment `sub_addr`, load the next byte, go to RDATA.
    - High (NACK, or the master leaves SCCB's don't-care bit released): increment `sub_addr`, go to IGNORE.
- `sub_addr` arithmetic is 8-bit and wraps from 8'hFF to 8'h00.
- `sub_addr` persists across transactions. A write of the sub-address alone, followed by a read transaction, therefore reads that register.
- If a START or STOP arrives mid-byte, the partial byte is discarded, no register is written and no `o_wr_valid` pulse is issued.

## Timing

- Reset values:
  - SDA released (Z).
  - `o_busy` = 0, `o_wr_valid` = 0, `o_wr_addr` = 8'h00, `o_wr_data` = 8'h00, `o_sub_addr` = 8'h00.
  - Register file all 8'h00.
  - FSM in IDLE.
- Latency from a bus pin edge to the internal detect is 3 `i_clk` cycles.
- SDA drive changes 1 cycle after the detected SCL falling edge.
- `o_wr_valid` asserts 1 cycle after the SCL rising edge of the 8th data bit is detected.
- The ACK slot opens on the SCL falling edge after bit 8 and is released on the SCL falling edge after bit 9.
- `o_busy` rises 1 cycle after a matching address byte completes and falls 1 cycle after STOP is detected.
- A STOP or START detected in the same cycle as an SCL edge takes priority over that edge.

## Configuration

- `SCCB_TARGET_ACK_EN` defined: the block drives SDA low during the 9th bit of DEV, SUB and WDATA, like an I2C device.
- Not defined: SDA stays released in those slots, matching SCCB's don't-care bit, so the master always samples 1.
- Address mismatch never drives SDA, in either configuration.

## Test plan

- Write transaction: START, 8'h42, 8'h12, 8'h80, STOP -> `o_wr_valid` pulses once with addr 8'h12, data 8'h80; `reg[8'h12]` = 8'h80; `o_sub_addr` = 8'h13.
- Read transaction: write 8'h42, 8'h12, STOP, then START, 8'h43, 8'h80 shifted back, NACK, STOP -> master receives 8'h80; `o_busy` is 0 after STOP.
- Address mismatch: START, 8'h60, 8'h05, 8'hAA, STOP -> no `o_wr_valid` pulse; SDA never driven; `o_busy` stays 0.
- Burst with wrap: START, 8'h42, 8'hFF, 8'h11, 8'h22, STOP -> writes `reg[8'hFF]` = 8'h11 and `reg[8'h00]` = 8'h22; `o_sub_addr` = 8'h01.
- Interruption: STOP after 4 bits of WDATA -> no write; the next full transaction completes normally. Asserting `i_rst` mid-byte -> SDA released and all outputs return to their reset values.
- ACK slot: with `SCCB_TARGET_ACK_EN` defined, the master samples 0 on the 9th bit of all three write bytes. Without it, the master samples 1.

Source files
------------

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target emulating an OV7670 register port at DEV_ADDR.
// It holds a 256 x 8 register file with an auto-incrementing sub-address
// pointer, and every accepted register write is mirrored on a one-cycle
// strobe port.
// Optional feature: define SCCB_TARGET_ACK_EN to pull SDA low in the ACK
// slot of the address, sub-address and write-data bytes, as an I2C device
// would. By default that slot is left released, which is SCCB's don't-care
// bit.
module sccb_target #(
    parameter logic [6:0] DEV_ADDR = 7'h21
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic       o_busy,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic [7:0] o_sub_addr
);

`ifdef SCCB_TARGET_ACK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DEV       = 4'd1;
    localparam logic [3:0] ST_DEV_ACK   = 4'd2;
    localparam logic [3:0] ST_SUB       = 4'd3;
    localparam logic [3:0] ST_SUB_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    logic [2:0] scl_sync;
    logic [2:0] sda_sync;
    logic [3:0] state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       rw;
    logic       ack_seen;
    logic       ack_low;
    logic       sda_oe;
    logic [7:0] mem [256];

    // Stages 0/1 form the synchronizer, stage 2 is the edge register.
    wire scl_s     = scl_sync[1];
    wire scl_d     = scl_sync[2];
    wire sda_s     = sda_sync[1];
    wire sda_d     = sda_sync[2];
    wire scl_rise  = scl_s & ~scl_d;
    wire scl_fall  = ~scl_s & scl_d;
    wire start_det = scl_s & scl_d & ~sda_s & sda_d;
    wire stop_det  = scl_s & scl_d & sda_s & ~sda_d;

    // The byte as it stands once the bit on SDA right now is shifted in.
    wire [7:0] byte_in = {shift[6:0], sda_s};

    // Open-drain output: only ever pull low or release.
    assign io_sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronize both bus lines; reset to the idle-high bus level so that
    // leaving reset creates no false edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the value
            // held before this edge, which is what makes a shift chain work.
            scl_sync <= {scl_sync[1:0], i_scl};
            sda_sync <= {sda_sync[1:0], io_sda};
        end
    end

    // Bus protocol FSM: START/STOP first, then bit sampling on SCL rise and
    // SDA updates on SCL fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            rw         <= 1'b0;
            ack_seen   <= 1'b0;
            ack_low    <= 1'b0;
            sda_oe     <= 1'b0;
            o_busy     <= 1'b0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= 8'h00;
            o_wr_data  <= 8'h00;
            o_sub_addr <= 8'h00;
            // NOTE: the register file must read back as zero after reset, so
            // it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < 256; i++) mem[i[7:0]] <= 8'h00;
        end else begin
            o_wr_valid <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                o_busy <= 1'b0;
            end else if (start_det) begin
                // Any partial byte is dropped here; nothing was committed yet.
                state    <= ST_DEV;
                bit_cnt  <= 3'd0;
                ack_seen <= 1'b0;
                sda_oe   <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_DEV: begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state    <= ST_DEV_ACK;
                                rw       <= byte_in[0];
                                ack_seen <= 1'b0;
                                o_busy   <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_SUB: begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            o_sub_addr <= byte_in;
                            state      <= ST_SUB_ACK;
                            ack_seen   <= 1'b0;
                        end
                    end
                    ST_WDATA: begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mem[o_sub_addr] <= byte_in;
                            o_wr_valid      <= 1'b1;
                            o_wr_addr       <= o_sub_addr;
                            o_wr_data       <= byte_in;
                            o_sub_addr      <= o_sub_addr + 8'd1;
                            state           <= ST_WDATA_ACK;
                            ack_seen        <= 1'b0;
                        end
                    end
                    ST_RDATA: begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state    <= ST_RDATA_ACK;
                            ack_seen <= 1'b0;
                        end
                    end
                    ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                        ack_seen <= 1'b1;
                    end
                    ST_RDATA_ACK: begin
                        // The pointer advances whether the master ACKs or not.
                        ack_seen   <= 1'b1;
                        ack_low    <= ~sda_s;
                        o_sub_addr <= o_sub_addr + 8'd1;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ST_RDATA: begin
                        sda_oe <= ~shift[7];
                    end
                    ST_DEV_ACK: begin
                        if (!ack_seen) begin
                            sda_oe <= ACK_EN;
                        end else if (rw) begin
                            // First read bit goes out on the same fall that closes the ACK.
                            state   <= ST_RDATA;
                            bit_cnt <= 3'd0;
                            shift   <= mem[o_sub_addr];
                            sda_oe  <= ~mem[o_sub_addr][7];
                        end else begin
                            state   <= ST_SUB;
                            bit_cnt <= 3'd0;
                            sda_oe  <= 1'b0;
                        end
                    end
                    ST_SUB_ACK, ST_WDATA_ACK: begin
                        if (!ack_seen) begin
                            sda_oe <= ACK_EN;
                        end else begin
                            state   <= ST_WDATA;
                            bit_cnt <= 3'd0;
                            sda_oe  <= 1'b0;
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (!ack_seen) begin
                            sda_oe <= 1'b0;
                        end else if (ack_low) begin
                            state   <= ST_RDATA;
                            bit_cnt <= 3'd0;
                            shift   <= mem[o_sub_addr];
                            sda_oe  <= ~mem[o_sub_addr][7];
                        end else begin
                            state  <= ST_IGNORE;
                            sda_oe <= 1'b0;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a timed bus master drives SCL/SDA through a pulled-up
// open-drain line; write transactions come from a vector table, and reads,
// wrap, interruption and mid-byte reset are hand-written sequences.
`timescale 1ns/1ps
module tb_sccb_target;

    localparam int TQ = 80;  // quarter SCL period in ns (SCL = 1/32 of i_clk)

`ifdef SCCB_TARGET_ACK_EN
    localparam bit EXP_ACK = 1'b0;
`else
    localparam bit EXP_ACK = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda_low;
    wire        sda;
    logic       busy;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] sub_addr;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    sccb_target #(.DEV_ADDR(7'h21)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl),
        .io_sda     (sda),
        .o_busy     (busy),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_sub_addr (sub_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Monitors sampled on the falling clock edge, away from the active edge.
    int         wr_pulses   = 0;
    int         busy_cycles = 0;
    logic [7:0] mon_addr    = 8'h00;
    logic [7:0] mon_data    = 8'h00;
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_pulses = wr_pulses + 1;
            mon_addr  = wr_addr;
            mon_data  = wr_data;
        end
        if (busy) busy_cycles = busy_cycles + 1;
    end

    int drive_viol = 0;  // released data bits of write bytes that read back low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_cond();
        m_sda_low = 1'b0; #TQ;
        scl = 1'b1;       #TQ;
        m_sda_low = 1'b1; #TQ;
        scl = 1'b0;       #TQ;
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1; #TQ;
        scl = 1'b1;       #TQ;
        m_sda_low = 1'b0; #(4*TQ);
    endtask

    task automatic xfer_bit(input bit b, output bit r);
        m_sda_low = !b; #TQ;
        scl = 1'b1;     #TQ;
        r = sda;        #TQ;
        scl = 1'b0;     #TQ;
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(d[i], r);
            if (d[i] && !r) drive_viol++;
        end
        xfer_bit(1'b1, ack);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] d);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            d[i] = r;
        end
        xfer_bit(nack, r);
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] sub;
        logic [7:0] data;
        bit         match;
        logic [7:0] exp_sub;
    } wvec_t;

    wvec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         a0, a1, a2, ra;
        int         p0, b0, v0;
        logic [7:0] rd0, rd1;

        vecs[0] = '{8'h42, 8'h12, 8'h80, 1'b1, 8'h13};
        vecs[1] = '{8'h60, 8'h05, 8'hAA, 1'b0, 8'h13};
        vecs[2] = '{8'h42, 8'h34, 8'h5A, 1'b1, 8'h35};
        vecs[3] = '{8'h44, 8'h77, 8'h01, 1'b0, 8'h35};
        vecs[4] = '{8'h42, 8'h00, 8'hFF, 1'b1, 8'h01};

        rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
        #100;
        rst = 1'b0;
        #100;
        check("reset sda released", sda, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset wr_valid", wr_valid, 1'b0);
        check("reset wr_addr", wr_addr, 8'h00);
        check("reset wr_data", wr_data, 8'h00);
        check("reset sub_addr", sub_addr, 8'h00);

        // Table-driven write transactions: START dev sub data STOP.
        for (int k = 0; k < 5; k++) begin
            p0 = wr_pulses; b0 = busy_cycles; v0 = drive_viol;
            start_cond();
            write_byte(vecs[k].dev, a0);
            write_byte(vecs[k].sub, a1);
            write_byte(vecs[k].data, a2);
            stop_cond();
            check($sformatf("v%0d pulses", k), wr_pulses - p0, vecs[k].match ? 1 : 0);
            if (vecs[k].match) begin
                check($sformatf("v%0d wr_addr", k), mon_addr, vecs[k].sub);
                check($sformatf("v%0d wr_data", k), mon_data, vecs[k].data);
            end
            check($sformatf("v%0d sub_addr", k), sub_addr, vecs[k].exp_sub);
            check($sformatf("v%0d busy seen", k), busy_cycles > b0, vecs[k].match);
            check($sformatf("v%0d busy after stop", k), busy, 1'b0);
            check($sformatf("v%0d ack dev", k), a0, vecs[k].match ? EXP_ACK : 1'b1);
            check($sformatf("v%0d ack sub", k), a1, vecs[k].match ? EXP_ACK : 1'b1);
            check($sformatf("v%0d ack data", k), a2, vecs[k].match ? EXP_ACK : 1'b1);
            check($sformatf("v%0d sda not driven", k), drive_viol - v0, 0);
        end

        // Read back reg 0x12 written by the first vector.
        p0 = wr_pulses;
        start_cond(); write_byte(8'h42, ra); write_byte(8'h12, ra); stop_cond();
        start_cond(); write_byte(8'h43, ra); read_byte(1'b1, rd0); stop_cond();
        check("read 12 data", rd0, 8'h80);
        check("read busy after stop", busy, 1'b0);
        check("read sub_addr", sub_addr, 8'h13);
        check("read no write pulse", wr_pulses - p0, 0);

        // Burst across the 0xFF -> 0x00 wrap, then a two-byte read with master ACK.
        p0 = wr_pulses;
        start_cond();
        write_byte(8'h42, ra); write_byte(8'hFF, ra);
        write_byte(8'h11, ra); write_byte(8'h22, ra);
        stop_cond();
        check("burst pulses", wr_pulses - p0, 2);
        check("burst last addr", mon_addr, 8'h00);
        check("burst last data", mon_data, 8'h22);
        check("burst sub_addr", sub_addr, 8'h01);
        start_cond(); write_byte(8'h42, ra); write_byte(8'hFF, ra); stop_cond();
        start_cond(); write_byte(8'h43, ra);
        read_byte(1'b0, rd0); read_byte(1'b1, rd1); stop_cond();
        check("burst read ff", rd0, 8'h11);
        check("burst read 00", rd1, 8'h22);
        check("burst read sub_addr", sub_addr, 8'h01);

        // STOP after 4 data bits: nothing written; next transaction is normal.
        p0 = wr_pulses;
        start_cond(); write_byte(8'h42, ra); write_byte(8'h20, ra);
        xfer_bit(1'b1, ra); xfer_bit(1'b0, ra); xfer_bit(1'b1, ra); xfer_bit(1'b0, ra);
        stop_cond();
        check("abort pulses", wr_pulses - p0, 0);
        check("abort sub_addr", sub_addr, 8'h20);
        check("abort busy", busy, 1'b0);
        start_cond(); write_byte(8'h42, ra); write_byte(8'h20, ra); write_byte(8'h33, ra);
        stop_cond();
        check("after abort pulses", wr_pulses - p0, 1);
        check("after abort addr", mon_addr, 8'h20);
        check("after abort data", mon_data, 8'h33);
        check("after abort sub_addr", sub_addr, 8'h21);

        // Reset mid-byte while the target is pulling SDA low in a read.
        start_cond(); write_byte(8'h42, ra); write_byte(8'h20, ra); stop_cond();
        start_cond(); write_byte(8'h43, ra);
        xfer_bit(1'b1, ra);            // bit 7 of 0x33 is 0; bit 6 (0) now driven
        check("read bit7 of 33", ra, 1'b0);
        check("target driving before reset", sda, 1'b0);
        rst = 1'b1;
        #30;
        check("in reset sda released", sda, 1'b1);
        check("in reset busy", busy, 1'b0);
        check("in reset sub_addr", sub_addr, 8'h00);
        check("in reset wr_addr", wr_addr, 8'h00);
        check("in reset wr_data", wr_data, 8'h00);
        check("in reset wr_valid", wr_valid, 1'b0);
        rst = 1'b0;
        #100;
        stop_cond();
        start_cond(); write_byte(8'h42, ra); write_byte(8'h20, ra); stop_cond();
        start_cond(); write_byte(8'h43, ra); read_byte(1'b1, rd0); stop_cond();
        check("reg cleared by reset", rd0, 8'h00);
        check("post reset sub_addr", sub_addr, 8'h21);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
